adder_vec_checker: RTL and testbench
====================================

ADDER_VEC_CHECKER -- requirements
Module: adder_vec_checker

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 25: number of (a, b, expected) vector triples held.
REQ-002 The block SHALL have parameter DW, default 8: operand and memory word width.
REQ-003 The block SHALL have parameter SETTLE, default 1 (minimum 1): cycles operands are held before the result is sampled.
REQ-004 clk  input  1  Single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  Reset, asynchronous and active-low.
REQ-006 wr_en  input  1  Vector memory write strobe.
REQ-007 wr_addr  input  8  Word address, 0..3*NUM_VEC-1.
REQ-008 wr_data  input  DW  Word to store.
REQ-009 start  input  1  Single-cycle run request.
REQ-010 a_out  output  DW  Operand a driven to the external adder.
REQ-011 b_out  output  DW  Operand b driven to the external adder.
REQ-012 y_in  input  DW+1  Adder sum returned.
REQ-013 busy  output  1  High while a run is in progress.
REQ-014 done  output  1  High from run completion until the next accepted start.
REQ-015 pass  output  1  Valid when done=1; 1 means zero mismatches.
REQ-016 err_cnt  output  8  Mismatch count for the current or last run.

Function
REQ-017 Memory SHALL be 3*NUM_VEC words of DW bits, laid out as word 3i = a, 3i+1 = b, 3i+2 = expected for vector i.
REQ-018 A write SHALL take effect when wr_en=1, busy=0 and wr_addr<3*NUM_VEC; all other writes SHALL be ignored without error.
REQ-019 The FSM SHALL use the states IDLE, FETCH_A, FETCH_B, FETCH_R, APPLY, CHECK and DONE.
REQ-020 IDLE or DONE with start=1 SHALL go to FETCH_A, clear err_cnt, done and pass, set vector index to 0, and set busy.
REQ-021 Memory reads SHALL be synchronous, one word per cycle: FETCH_A loads a_out, FETCH_B loads b_out, FETCH_R loads the expected register.
REQ-022 APPLY SHALL hold a_out and b_out stable for SETTLE cycles, then go to CHECK.
REQ-023 CHECK SHALL compare y_in with the zero-extended expected value (DW+1 bits) and increment err_cnt on mismatch, saturating at 255.
REQ-024 CHECK SHALL go to FETCH_A with index+1, or to DONE if index=NUM_VEC-1.
REQ-025 Each vector SHALL take exactly 4+SETTLE cycles; a run SHALL take NUM_VEC*(4+SETTLE) cycles (125 at defaults) from the start edge to done=1.
REQ-026 In DONE, busy SHALL be 0, done SHALL be 1, pass SHALL be (err_cnt==0), and a_out, b_out and err_cnt SHALL hold their values.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 A carry-out mismatch SHALL count as an error, because expected bit DW is always 0.

Reset
REQ-029 While rst_n=0, at any time including mid-run, the FSM SHALL return to IDLE and a_out, b_out, busy, done, pass and err_cnt SHALL be 0.
REQ-030 Reset SHALL NOT clear memory contents.

Structure
REQ-031 The state encoding and the default values of NUM_VEC, DW and SETTLE SHALL live in the shared package adder_tb_pkg.
REQ-032 The vector memory SHALL be a separate sub-module, vec_mem (one write port, one synchronous read port).
REQ-033 The external adder SHALL NOT be instantiated inside this block.

Verification
REQ-034 Load words (i, i, 2i) for i=0..24, connect to the 8-bit adder, pulse start -> done=1 after 125 cycles, pass=1, err_cnt=0.
REQ-035 Same load with word 23 overwritten to 0x00 -> err_cnt=1, pass=0.
REQ-036 Vector 0 = (0xFF, 0x01, 0x00) -> y_in=0x100 counted as a mismatch, err_cnt=1.
REQ-037 Pulse start again at cycle 50 of a run -> run unaffected, done still at cycle 125; a write during busy is not stored.
REQ-038 Drop rst_n at cycle 60 -> all outputs 0 immediately; after release, a new start gives the same result as REQ-034 with no reload.

Source files
------------

// File: rtl/adder_vec_checker_pkg.sv
// Shared definitions for the adder vector checker: default geometry and FSM encoding.
package adder_tb_pkg;

    localparam int NUM_VEC_DEF = 25;
    localparam int DW_DEF      = 8;
    localparam int SETTLE_DEF  = 1;
    localparam int AW          = 8;   // external word-address width

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        FETCH_R = 3'd3,
        APPLY   = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/adder_vec_checker_if.sv
// Bundle of the load, run-control and adder-facing signals of the vector checker.
interface adder_vec_checker_if import adder_tb_pkg::*; #(
    parameter int DW = DW_DEF
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [DW:0]   y_in;
    logic          busy;
    logic          done;
    logic          pass;
    logic [7:0]    err_cnt;

    // Environment side: loads vectors, starts runs, closes the loop through the adder.
    modport master (
        output wr_en, wr_addr, wr_data, start, y_in,
        input  a_out, b_out, busy, done, pass, err_cnt
    );

    // Checker side.
    modport slave (
        input  wr_en, wr_addr, wr_data, start, y_in,
        output a_out, b_out, busy, done, pass, err_cnt
    );
endinterface

// File: rtl/vec_mem.sv
// Vector store: one write port and one registered read port. Contents are never reset.
module vec_mem #(
    parameter int DEPTH = 75,
    parameter int DW    = 8,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Synchronous write and read; a same-edge read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/adder_vec_checker.sv
// Plays stored (a, b, expected) vectors into an external adder and counts result mismatches.
module adder_vec_checker import adder_tb_pkg::*; #(
    parameter int NUM_VEC = NUM_VEC_DEF,
    parameter int DW      = DW_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_vec_checker_if.slave   bus
);
    localparam int DEPTH = 3 * NUM_VEC;
    localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          state_reg, state_next;
    logic [7:0]      idx_reg;
    logic [MAW-1:0]  base_reg;      // word address of the current vector's a operand
    logic [15:0]     settle_reg;
    logic [DW-1:0]   a_reg, b_reg, exp_reg;
    logic [7:0]      err_reg;
    logic [MAW-1:0]  rd_addr;
    logic [DW-1:0]   rd_data;
    logic            mem_we;
    logic            start_ok, last_vec, settle_last, mismatch;
    logic            busy, done, pass;

    assign start_ok    = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign last_vec    = (idx_reg == 8'(NUM_VEC - 1));
    assign settle_last = (settle_reg == 16'(SETTLE - 1));
    // Expected word has a zero carry bit, so any adder carry-out is a mismatch.
    assign mismatch    = (bus.y_in != {1'b0, exp_reg});
    assign mem_we      = bus.wr_en && !busy && (int'(bus.wr_addr) < DEPTH);

    vec_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (MAW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.wr_addr[MAW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Read address runs one word ahead of the consuming state, hiding the read latency.
    always_comb begin
        rd_addr = '0;
        case (state_reg)
            FETCH_A: rd_addr = base_reg + MAW'(1);
            FETCH_B: rd_addr = base_reg + MAW'(2);
            CHECK:   rd_addr = last_vec ? '0 : base_reg + MAW'(3);
            default: rd_addr = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (bus.start) state_next = FETCH_A;
            FETCH_A:    state_next = FETCH_B;
            FETCH_B:    state_next = FETCH_R;
            FETCH_R:    state_next = APPLY;
            APPLY:      if (settle_last) state_next = CHECK;
            CHECK:      state_next = last_vec ? DONE : FETCH_A;
            default:    state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state; done/pass drop as soon as a new run starts.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state_reg)
            IDLE: ;
            DONE: begin
                done = 1'b1;
                pass = (err_reg == 8'd0);
            end
            default: busy = 1'b1;
        endcase
    end

    // Datapath: operand/expected capture, settle timer, vector index and error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            exp_reg    <= '0;
            err_reg    <= '0;
            idx_reg    <= '0;
            base_reg   <= '0;
            settle_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_ok) begin
                        err_reg  <= '0;
                        idx_reg  <= '0;
                        base_reg <= '0;
                    end
                end
                FETCH_A: a_reg <= rd_data;
                FETCH_B: b_reg <= rd_data;
                FETCH_R: begin
                    exp_reg    <= rd_data;
                    settle_reg <= '0;
                end
                APPLY: settle_reg <= settle_reg + 16'd1;
                CHECK: begin
                    if (mismatch && err_reg != 8'hFF) begin
                        err_reg <= err_reg + 8'd1;
                    end
                    if (!last_vec) begin
                        idx_reg  <= idx_reg + 8'd1;
                        base_reg <= base_reg + MAW'(3);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.a_out   = a_reg;
    assign bus.b_out   = b_reg;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.pass    = pass;
    assign bus.err_cnt = err_reg;

endmodule

// File: tb/tb_adder_vec_checker.sv
// Directed bench for adder_vec_checker closing the loop through a behavioural 8-bit adder.
module tb_adder_vec_checker;
    import adder_tb_pkg::*;

    localparam int DW      = 8;
    localparam int NUM_VEC = 25;
    localparam int SETTLE  = 1;
    localparam int RUN_CYC = 125;
    localparam int LIMIT   = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    adder_vec_checker_if #(.DW(DW)) bus ();

    adder_vec_checker #(
        .NUM_VEC (NUM_VEC),
        .DW      (DW),
        .SETTLE  (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // External adder in the loop.
    assign bus.y_in = {1'b0, bus.a_out} + {1'b0, bus.b_out};

    task automatic write_word(input int addr, input logic [7:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        $display("write addr=%0d data=0x%02h", addr, data);
    endtask

    task automatic load_default();
        for (int i = 0; i < NUM_VEC; i++) begin
            write_word(3 * i,     8'(i));
            write_word(3 * i + 1, 8'(i));
            write_word(3 * i + 2, 8'(2 * i));
        end
    endtask

    // Pulse start, optionally re-pulse start plus a write at hook_at, count cycles to done.
    task automatic run(input int hook_at, output int cycles);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        cycles = 0;
        while (!bus.done && cycles < LIMIT) begin
            if (cycles == hook_at) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = 8'd5;
                bus.wr_data = 8'h77;
            end else begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        $display("run cycles=%0d done=%0b pass=%0b err_cnt=%0d", cycles, bus.done, bus.pass, bus.err_cnt);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        n_cmp++; if (bus.pass !== 1'b0)     begin n_bad++; $display("FAIL reset_pass got=%b want=0", bus.pass); end
        n_cmp++; if (bus.err_cnt !== 8'd0)  begin n_bad++; $display("FAIL reset_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.a_out !== 8'd0)    begin n_bad++; $display("FAIL reset_a got=%0h want=0", bus.a_out); end
        n_cmp++; if (bus.b_out !== 8'd0)    begin n_bad++; $display("FAIL reset_b got=%0h want=0", bus.b_out); end
    endtask

    task automatic test_basic();
        int cyc;
        run(-1, cyc);
        n_cmp++; if (cyc !== RUN_CYC)      begin n_bad++; $display("FAIL basic_latency got=%0d want=%0d", cyc, RUN_CYC); end
        n_cmp++; if (bus.pass !== 1'b1)    begin n_bad++; $display("FAIL basic_pass got=%b want=1", bus.pass); end
        n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL basic_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.busy !== 1'b0)    begin n_bad++; $display("FAIL basic_busy got=%b want=0", bus.busy); end
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1)    begin n_bad++; $display("FAIL basic_done_hold got=%b want=1", bus.done); end
        n_cmp++; if (bus.a_out !== 8'd24)  begin n_bad++; $display("FAIL basic_a_hold got=%0d want=24", bus.a_out); end
        n_cmp++; if (bus.b_out !== 8'd24)  begin n_bad++; $display("FAIL basic_b_hold got=%0d want=24", bus.b_out); end
    endtask

    task automatic test_bad_expected();
        int cyc;
        write_word(23, 8'h00);            // vector 7 expected 14 -> 0
        run(-1, cyc);
        n_cmp++; if (bus.err_cnt !== 8'd1) begin n_bad++; $display("FAIL badexp_err got=%0d want=1", bus.err_cnt); end
        n_cmp++; if (bus.pass !== 1'b0)    begin n_bad++; $display("FAIL badexp_pass got=%b want=0", bus.pass); end
        n_cmp++; if (bus.done !== 1'b1)    begin n_bad++; $display("FAIL badexp_done got=%b want=1", bus.done); end
        write_word(23, 8'd14);
    endtask

    task automatic test_carry();
        int cyc;
        write_word(0, 8'hFF);
        write_word(1, 8'h01);
        write_word(2, 8'h00);
        write_word(200, 8'h55);           // out of range, must be dropped
        run(-1, cyc);
        n_cmp++; if (bus.err_cnt !== 8'd1) begin n_bad++; $display("FAIL carry_err got=%0d want=1", bus.err_cnt); end
        n_cmp++; if (bus.pass !== 1'b0)    begin n_bad++; $display("FAIL carry_pass got=%b want=0", bus.pass); end
        n_cmp++; if (bus.a_out !== 8'd24)  begin n_bad++; $display("FAIL oob_write_a got=%0d want=24", bus.a_out); end
        write_word(0, 8'h00);
        write_word(1, 8'h00);
        write_word(2, 8'h00);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run(50, cyc);
        n_cmp++; if (cyc !== RUN_CYC)      begin n_bad++; $display("FAIL restart_latency got=%0d want=%0d", cyc, RUN_CYC); end
        n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL restart_err got=%0d want=0", bus.err_cnt); end
        run(-1, cyc);
        n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL busy_write_err got=%0d want=0", bus.err_cnt); end
        n_cmp++; if (bus.pass !== 1'b1)    begin n_bad++; $display("FAIL busy_write_pass got=%b want=1", bus.pass); end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (59) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1)    begin n_bad++; $display("FAIL midrun_busy got=%b want=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        $display("reset asserted mid-run");
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(-1, cyc);
        n_cmp++; if (cyc !== RUN_CYC)      begin n_bad++; $display("FAIL postrst_latency got=%0d want=%0d", cyc, RUN_CYC); end
        n_cmp++; if (bus.pass !== 1'b1)    begin n_bad++; $display("FAIL postrst_pass got=%b want=1", bus.pass); end
        n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL postrst_err got=%0d want=0", bus.err_cnt); end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = 8'd0;
        bus.wr_data = 8'd0;
        bus.start   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        load_default();
        test_basic();
        test_bad_expected();
        test_carry();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
